// File: rtl/oc8051_pf_pkg.sv
// Shared constants and types for the oc8051 code-ROM prefetch buffer.
//   PF_FETCH_BYTES : bytes delivered by one ROM read (4-byte-wide port)
//   PF_MAX_INSN    : longest 8051 instruction, i.e. bytes shown to decode
//   PF_DEPTH       : default queue capacity in bytes
//   PF_AW          : code address width
package oc8051_pf_pkg;
  localparam int PF_FETCH_BYTES = 4;
  localparam int PF_MAX_INSN    = 3;
  localparam int PF_DEPTH       = 8;
  localparam int PF_AW          = 16;

  typedef logic [7:0]       pf_byte_t;
  typedef logic [PF_AW-1:0] pf_addr_t;
endpackage

// File: rtl/oc8051_pf_bytebuf.sv
// Circular byte queue for the prefetch buffer.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   flush    : discard contents and load wr_data at slot 0 (redirect)
//   wr_en    : append wr_data (4 bytes) at the tail
//   wr_data  : 4 bytes, [7:0] first in code order
//   adv      : bytes removed from the head this cycle (caller keeps adv <= cnt)
//   rd_data  : 3-byte window starting at the head, [7:0] = head byte
//   cnt      : number of valid bytes held
module oc8051_pf_bytebuf
  import oc8051_pf_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [8*PF_FETCH_BYTES-1:0] wr_data,
  input  logic [1:0]                  adv,
  output logic [8*PF_MAX_INSN-1:0]    rd_data,
  output logic [CW-1:0]               cnt
);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  pf_byte_t mem_q [DEPTH];
  pf_byte_t mem_d [DEPTH];
  ptr_t     head_q, head_d;
  ptr_t     tail_q, tail_d;
  ptr_t     wptr;
  cnt_t     cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wptr  = flush ? '0 : tail_q;
    // The caller only writes when at least 4 slots are free after this
    // cycle's consume, so the write never lands on a byte still in use.
    if (flush || wr_en) begin
      for (int i = 0; i < PF_FETCH_BYTES; i++) begin
        mem_d[wptr + ptr_t'(i)] = wr_data[8*i +: 8];
      end
    end

    if (flush) begin
      head_d = '0;
      tail_d = ptr_t'(PF_FETCH_BYTES);
      cnt_d  = cnt_t'(PF_FETCH_BYTES);
    end else begin
      head_d = head_q + ptr_t'(adv);
      tail_d = wr_en ? tail_q + ptr_t'(PF_FETCH_BYTES) : tail_q;
      cnt_d  = cnt_q - cnt_t'(adv) + (wr_en ? cnt_t'(PF_FETCH_BYTES) : cnt_t'(0));
    end
  end

  always_comb begin
    for (int i = 0; i < PF_MAX_INSN; i++) begin
      rd_data[8*i +: 8] = mem_q[head_q + ptr_t'(i)];
    end
  end

  assign cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Byte storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/oc8051_cxrom_prefetch.sv
// Instruction prefetch buffer between the 32-bit combinational code ROM
// and the oc8051 fetch/decode logic.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cxrom_addr     : ROM byte address of the current 4-byte read
//   cxrom_data_in  : ROM data for cxrom_addr, [7:0] = byte at cxrom_addr
//   pf_jmp         : redirect request, pf_jmp_addr = target
//   pf_cons        : bytes consumed this cycle (0..3), clamped to pf_cnt
//   pf_pc          : code address of pf_data[7:0]
//   pf_data        : next 3 code bytes, [7:0] at pf_pc
//   pf_cnt         : valid bytes in the queue
//   pf_err         : sticky over-consume flag
// Build option: define OC8051_PF_CHECK_EN to enable the over-consume
// check on pf_err; otherwise pf_err is tied low.
module oc8051_cxrom_prefetch
  import oc8051_pf_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PF_AW-1:0]         cxrom_addr,
  input  logic [31:0]              cxrom_data_in,
  input  logic                     pf_jmp,
  input  logic [PF_AW-1:0]         pf_jmp_addr,
  input  logic [1:0]               pf_cons,
  output logic [PF_AW-1:0]         pf_pc,
  output logic [8*PF_MAX_INSN-1:0] pf_data,
  output logic [CW-1:0]            pf_cnt,
  output logic                     pf_err
);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   wide_t;

  pf_addr_t fetch_addr_q, fetch_addr_d;
  pf_addr_t pf_pc_q, pf_pc_d;
  cnt_t     cnt;
  cnt_t     cons_eff;
  wide_t    free_after;
  logic     fill;
  logic [1:0] adv;

  always_comb begin
    cons_eff   = (cnt_t'(pf_cons) < cnt) ? cnt_t'(pf_cons) : cnt;
    // Space available once this cycle's consumed bytes are released.
    free_after = wide_t'(DEPTH) - wide_t'(cnt) + wide_t'(cons_eff);
    fill       = !pf_jmp && (free_after >= wide_t'(PF_FETCH_BYTES));
    adv        = pf_jmp ? 2'd0 : 2'(cons_eff);
    cxrom_addr = pf_jmp ? pf_jmp_addr : fetch_addr_q;

    fetch_addr_d = fetch_addr_q;
    pf_pc_d      = pf_pc_q;
    if (pf_jmp) begin
      fetch_addr_d = pf_jmp_addr + pf_addr_t'(PF_FETCH_BYTES);
      pf_pc_d      = pf_jmp_addr;
    end else begin
      if (fill) fetch_addr_d = fetch_addr_q + pf_addr_t'(PF_FETCH_BYTES);
      pf_pc_d = pf_pc_q + pf_addr_t'(cons_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q <= '0;
      pf_pc_q      <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      pf_pc_q      <= pf_pc_d;
    end
  end

  oc8051_pf_bytebuf #(.DEPTH(DEPTH)) u_bytebuf (
    .clk     (clk),
    .rst     (rst),
    .flush   (pf_jmp),
    .wr_en   (fill),
    .wr_data (cxrom_data_in),
    .adv     (adv),
    .rd_data (pf_data),
    .cnt     (cnt)
  );

  assign pf_pc  = pf_pc_q;
  assign pf_cnt = cnt;

`ifdef OC8051_PF_CHECK_EN
  logic pf_err_q, pf_err_d, proto_viol;

  always_comb begin
    proto_viol = !pf_jmp && (cnt_t'(pf_cons) > cnt);
    pf_err_d   = pf_err_q | proto_viol;
  end

  always_ff @(posedge clk) begin
    if (rst) pf_err_q <= 1'b0;
    else     pf_err_q <= pf_err_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && proto_viol)
      $display("[oc8051_pf] over-consume at %0t: pf_cons=%0d pf_cnt=%0d", $time, pf_cons, cnt);
  end
`endif

  assign pf_err = pf_err_q;
`else
  assign pf_err = 1'b0;
`endif
endmodule

// File: tb/tb_oc8051_cxrom_prefetch.sv
module tb_oc8051_cxrom_prefetch;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef OC8051_PF_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef logic [CW-1:0] cnt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cxrom_addr;
  logic [31:0]   cxrom_data_in;
  logic          pf_jmp = 1'b0;
  logic [15:0]   pf_jmp_addr = '0;
  logic [1:0]    pf_cons = '0;
  logic [15:0]   pf_pc;
  logic [23:0]   pf_data;
  logic [CW-1:0] pf_cnt;
  logic          pf_err;

  int tests  = 0;
  int failed = 0;
  int rom_mode = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input int mode, input logic [15:0] a);
    if (mode == 0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign cxrom_data_in = {rom_byte(rom_mode, cxrom_addr + 16'd3), rom_byte(rom_mode, cxrom_addr + 16'd2),
                          rom_byte(rom_mode, cxrom_addr + 16'd1), rom_byte(rom_mode, cxrom_addr)};

  oc8051_cxrom_prefetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cxrom_addr(cxrom_addr), .cxrom_data_in(cxrom_data_in),
    .pf_jmp(pf_jmp), .pf_jmp_addr(pf_jmp_addr), .pf_cons(pf_cons),
    .pf_pc(pf_pc), .pf_data(pf_data), .pf_cnt(pf_cnt), .pf_err(pf_err)
  );

  // Reference model: a queue of code bytes in program order.
  logic [7:0]  mq[$];
  logic [15:0] m_pc, m_fetch;
  bit          m_err;
  logic [15:0] obs_addr, exp_addr;

  task automatic apply_reset();
    rst = 1'b1; pf_jmp = 1'b0; pf_jmp_addr = '0; pf_cons = '0;
    @(posedge clk); #1;
    obs_addr = cxrom_addr;
    mq.delete(); m_pc = '0; m_fetch = '0; m_err = 1'b0;
    exp_addr = '0;
  endtask

  // Drive one cycle, sample cxrom_addr before the edge, advance the model.
  task automatic do_cycle(input bit jmp, input logic [15:0] ja, input int cons);
    int ce, free;
    rst = 1'b0; pf_jmp = jmp; pf_jmp_addr = ja; pf_cons = cons[1:0];
    #1;
    obs_addr = cxrom_addr;
    exp_addr = jmp ? ja : m_fetch;
    if (jmp) begin
      mq.delete();
      for (int i = 0; i < 4; i++) mq.push_back(rom_byte(rom_mode, 16'(ja + 16'(i))));
      m_pc = ja; m_fetch = 16'(ja + 16'd4);
    end else begin
      ce = (cons < mq.size()) ? cons : mq.size();
      if (cons > mq.size()) m_err = 1'b1;
      free = DEPTH - mq.size() + ce;
      repeat (ce) void'(mq.pop_front());
      m_pc = 16'(m_pc + 16'(ce));
      if (free >= 4) begin
        for (int i = 0; i < 4; i++) mq.push_back(rom_byte(rom_mode, 16'(m_fetch + 16'(i))));
        m_fetch = 16'(m_fetch + 16'd4);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (pf_cnt !== '0) begin failed++; $display("FAIL reset_cnt got %0d want 0", pf_cnt); end
    tests++; if (pf_pc !== 16'h0) begin failed++; $display("FAIL reset_pc got %h want 0000", pf_pc); end
    tests++; if (obs_addr !== 16'h0) begin failed++; $display("FAIL reset_addr got %h want 0000", obs_addr); end
    tests++; if (pf_err !== 1'b0) begin failed++; $display("FAIL reset_err got %b want 0", pf_err); end
  endtask

  task automatic test_idle_fill();
    rom_mode = 0;
    apply_reset();
    do_cycle(0, 16'h0, 0);
    tests++; if (obs_addr !== 16'h0000) begin failed++; $display("FAIL idle_addr0 got %h want 0000", obs_addr); end
    tests++; if (pf_cnt !== cnt_t'(4)) begin failed++; $display("FAIL idle_cnt1 got %0d want 4", pf_cnt); end
    tests++; if (pf_data !== 24'h020100) begin failed++; $display("FAIL idle_data1 got %h want 020100", pf_data); end
    tests++; if (pf_pc !== 16'h0000) begin failed++; $display("FAIL idle_pc1 got %h want 0000", pf_pc); end
    do_cycle(0, 16'h0, 0);
    tests++; if (pf_cnt !== cnt_t'(8)) begin failed++; $display("FAIL idle_cnt2 got %0d want 8", pf_cnt); end
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 16'h0, 0);
      tests++; if (pf_cnt !== cnt_t'(8)) begin failed++; $display("FAIL idle_cnt_hold got %0d want 8", pf_cnt); end
      tests++; if (obs_addr !== 16'h0008) begin failed++; $display("FAIL idle_addr_hold got %h want 0008", obs_addr); end
    end
  endtask

  task automatic test_steady_cons3();
    logic [15:0] pc;
    pc = pf_pc;
    for (int k = 0; k < 20; k++) begin
      do_cycle(0, 16'h0, 3);
      pc = 16'(pc + 16'd3);
      tests++; if (pf_pc !== pc) begin failed++; $display("FAIL steady_pc got %h want %h", pf_pc, pc); end
      tests++;
      if (pf_data !== {8'(pc + 16'd2), 8'(pc + 16'd1), pc[7:0]}) begin
        failed++; $display("FAIL steady_data got %h want %h", pf_data, {8'(pc + 16'd2), 8'(pc + 16'd1), pc[7:0]});
      end
    end
  endtask

  task automatic test_redirect();
    rom_mode = 0;
    apply_reset();
    do_cycle(0, 16'h0, 0);
    do_cycle(0, 16'h0, 0);
    do_cycle(0, 16'h0, 1);
    tests++; if (pf_cnt !== cnt_t'(7)) begin failed++; $display("FAIL redir_pre_cnt got %0d want 7", pf_cnt); end
    do_cycle(1, 16'h1235, 2);
    tests++; if (obs_addr !== 16'h1235) begin failed++; $display("FAIL redir_addr got %h want 1235", obs_addr); end
    tests++; if (pf_pc !== 16'h1235) begin failed++; $display("FAIL redir_pc got %h want 1235", pf_pc); end
    tests++; if (pf_cnt !== cnt_t'(4)) begin failed++; $display("FAIL redir_cnt got %0d want 4", pf_cnt); end
    tests++; if (pf_data !== 24'h373635) begin failed++; $display("FAIL redir_data got %h want 373635", pf_data); end
    do_cycle(0, 16'h0, 0);
    tests++; if (obs_addr !== 16'h1239) begin failed++; $display("FAIL redir_next_addr got %h want 1239", obs_addr); end
  endtask

  task automatic test_wrap();
    logic [15:0] pcs [4];
    pcs[0] = 16'hFFFE; pcs[1] = 16'hFFFF; pcs[2] = 16'h0000; pcs[3] = 16'h0001;
    rom_mode = 0;
    do_cycle(1, 16'hFFFE, 0);
    for (int k = 0; k < 4; k++) begin
      tests++; if (pf_pc !== pcs[k]) begin failed++; $display("FAIL wrap_pc got %h want %h", pf_pc, pcs[k]); end
      tests++; if (pf_data[7:0] !== pcs[k][7:0]) begin failed++; $display("FAIL wrap_byte got %h want %h", pf_data[7:0], pcs[k][7:0]); end
      do_cycle(0, 16'h0, 1);
      if (k == 0) begin
        tests++; if (obs_addr !== 16'h0002) begin failed++; $display("FAIL wrap_fetch got %h want 0002", obs_addr); end
      end
    end
  endtask

  task automatic test_midreset();
    rom_mode = 0;
    do_cycle(1, 16'h003E, 0);
    do_cycle(0, 16'h0, 0);
    do_cycle(0, 16'h0, 2);
    tests++; if (pf_cnt !== cnt_t'(6) || pf_pc !== 16'h0040) begin
      failed++; $display("FAIL midrst_pre got cnt=%0d pc=%h want cnt=6 pc=0040", pf_cnt, pf_pc);
    end
    apply_reset();
    tests++; if (pf_cnt !== '0) begin failed++; $display("FAIL midrst_cnt got %0d want 0", pf_cnt); end
    tests++; if (pf_pc !== 16'h0) begin failed++; $display("FAIL midrst_pc got %h want 0000", pf_pc); end
    tests++; if (obs_addr !== 16'h0) begin failed++; $display("FAIL midrst_addr got %h want 0000", obs_addr); end
    do_cycle(0, 16'h0, 0);
    tests++; if (pf_cnt !== cnt_t'(4) || pf_data !== 24'h020100) begin
      failed++; $display("FAIL midrst_restart got cnt=%0d data=%h want cnt=4 data=020100", pf_cnt, pf_data);
    end
  endtask

  task automatic test_err();
    rom_mode = 0;
    apply_reset();
    do_cycle(0, 16'h0, 3);   // pf_cnt is 0 here, so consume clamps to 0
    tests++; if (pf_pc !== 16'h0) begin failed++; $display("FAIL err_pc got %h want 0000", pf_pc); end
    tests++; if (pf_cnt !== cnt_t'(4)) begin failed++; $display("FAIL err_cnt got %0d want 4", pf_cnt); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (pf_err !== CHK) begin failed++; $display("FAIL err_sticky got %b want %b", pf_err, CHK); end
      do_cycle(0, 16'h0, 0);
    end
    apply_reset();
    tests++; if (pf_err !== 1'b0) begin failed++; $display("FAIL err_clear got %b want 0", pf_err); end
  endtask

  task automatic test_random();
    bit jmp;
    logic [15:0] ja;
    rom_mode = 1;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      jmp = ($urandom_range(0, 11) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      do_cycle(jmp, ja, $urandom_range(0, 3));
      tests++; if (obs_addr !== exp_addr) begin failed++; $display("FAIL rand_addr got %h want %h", obs_addr, exp_addr); end
      tests++; if (pf_cnt !== cnt_t'(mq.size())) begin failed++; $display("FAIL rand_cnt got %0d want %0d", pf_cnt, mq.size()); end
      tests++; if (pf_pc !== m_pc) begin failed++; $display("FAIL rand_pc got %h want %h", pf_pc, m_pc); end
      for (int i = 0; i < 3 && i < mq.size(); i++) begin
        tests++; if (pf_data[8*i +: 8] !== mq[i]) begin failed++; $display("FAIL rand_byte%0d got %h want %h", i, pf_data[8*i +: 8], mq[i]); end
      end
      tests++; if (pf_err !== (CHK & m_err)) begin failed++; $display("FAIL rand_err got %b want %b", pf_err, CHK & m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_fill();
    test_steady_cons3();
    test_redirect();
    test_wrap();
    test_midreset();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
